// File: rtl/egk_pkg.sv
// Shared definitions for the EGk binarizer / debinarizer pair.
package egk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        SUFFIX = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Width needed to hold an order/count in the range 0..n inclusive.
    function automatic int k_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/egk_debinarizer.sv
// Serial k-th order Exp-Golomb debinarizer: one bin per handshake,
// reconstructs the unsigned magnitude and the number of bins consumed.
module egk_debinarizer
    import egk_pkg::*;
#(
    parameter int N          = 8,
    parameter int bins_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            K,
    input  logic                  bin_valid,
    input  logic                  bin,
    output logic                  bin_ready,
    output logic                  done,
    output logic [N-1:0]          value,
    output logic [bins_width-1:0] bin_len,
    output logic                  err
);

    localparam int KW = k_width(N);

    state_t                state, state_n;
    logic [KW-1:0]         k, k_n;
    logic [KW-1:0]         cnt, cnt_n;
    logic [N:0]            acc, acc_n;
    logic [bins_width-1:0] len_n, len_inc;
    logic                  err_n;
    logic [N-1:0]          value_n;
    logic                  hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            cnt     <= '0;
            acc     <= '0;
            bin_len <= '0;
            err     <= 1'b0;
            value   <= '0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            bin_len <= len_n;
            err     <= err_n;
            value   <= value_n;
        end
    end

    assign bin_ready = (state == PREFIX) || (state == SUFFIX);
    assign done      = (state == FINISH);
    assign hs        = bin_valid && bin_ready;
    assign len_inc   = (bin_len == '1) ? bin_len : bin_len + bins_width'(1);

    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        acc_n   = acc;
        len_n   = bin_len;
        err_n   = err;
        value_n = value;

        case (state)
            IDLE: begin
                if (start) begin
                    k_n     = KW'(K);
                    cnt_n   = '0;
                    acc_n   = '0;
                    len_n   = '0;
                    err_n   = 1'b0;
                    value_n = '0;
                    // Compare at full width so orders wider than k cannot alias.
                    if (int'(K) >= N) begin
                        err_n   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        state_n = PREFIX;
                    end
                end
            end
            PREFIX: begin
                if (hs) begin
                    len_n = len_inc;
                    if (bin) begin
                        if (k == KW'(N)) begin
                            err_n   = 1'b1;
                            state_n = FINISH;
                        end else begin
                            acc_n = acc + ((N+1)'(1) << k);
                            k_n   = k + KW'(1);
                        end
                    end else begin
                        cnt_n   = k;
                        state_n = (k == '0) ? FINISH : SUFFIX;
                    end
                end
            end
            SUFFIX: begin
                if (hs) begin
                    // Suffix arrives MSB first; cnt is always >= 1 here.
                    acc_n = acc + ((N+1)'(bin) << (cnt - KW'(1)));
                    cnt_n = cnt - KW'(1);
                    len_n = len_inc;
                    if (acc_n[N]) begin
                        err_n   = 1'b1;
                        state_n = FINISH;
                    end else if (cnt == KW'(1)) begin
                        state_n = FINISH;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Results are published on the edge that enters FINISH.
        if (state != FINISH && state_n == FINISH) begin
            value_n = err_n ? '0 : acc_n[N-1:0];
        end
    end

endmodule

// File: tb/tb_egk_debinarizer.sv
// Directed self-checking bench for egk_debinarizer (N=8).
module tb_egk_debinarizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  K;
    logic        bin_valid;
    logic        bin;
    logic        bin_ready;
    logic        done;
    logic [7:0]  value;
    logic [15:0] bin_len;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int startCyc;
    int doneCyc;

    egk_debinarizer #(.N(8), .bins_width(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .K         (K),
        .bin_valid (bin_valid),
        .bin       (bin),
        .bin_ready (bin_ready),
        .done      (done),
        .value     (value),
        .bin_len   (bin_len),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startDecode(input logic [3:0] order);
        @(negedge clk);
        start = 1'b1;
        K     = order;
        @(negedge clk);
        start = 1'b0;
        startCyc = cyc;
    endtask

    task automatic applyStimulus(input logic b);
        bin_valid = 1'b1;
        bin       = b;
        @(negedge clk);
        bin_valid = 1'b0;
        bin       = 1'b0;
    endtask

    task automatic sendBins(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) applyStimulus(v[i]);
    endtask

    // Called in the cycle right after the last handshake.
    task automatic checkResult(input string tag, input logic [7:0] expVal,
                               input logic [15:0] expLen, input logic expErr);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_value"}, value, expVal);
        checkOutput({tag, "_len"}, bin_len, expLen);
        checkOutput({tag, "_err"}, err, expErr);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, done, 0);
        checkOutput({tag, "_hold"}, value, expVal);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        K         = '0;
        bin_valid = 1'b0;
        bin       = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", bin_ready, 0);
        checkOutput("rst_value", value, 0);
        checkOutput("rst_len", bin_len, 0);
        checkOutput("rst_err", err, 0);
        rst_n = 1'b1;

        startDecode(4'd0);
        checkOutput("k0_ready", bin_ready, 1);
        sendBins(32'b0, 1);
        checkResult("k0_0", 8'd0, 16'd1, 1'b0);

        startDecode(4'd0);
        sendBins(32'b11010, 5);
        checkResult("k0_11010", 8'd5, 16'd5, 1'b0);
        @(negedge clk);
        checkOutput("k0_11010_held", value, 5);

        // K=1 '1001' with a three-cycle gap between the 2nd and 3rd bins.
        startDecode(4'd1);
        sendBins(32'b10, 2);
        repeat (3) begin
            checkOutput("stall_ready", bin_ready, 1);
            @(negedge clk);
            checkOutput("stall_nodone", done, 0);
        end
        sendBins(32'b01, 2);
        for (int n = 0; n < 20 && !done; n++) @(negedge clk);
        doneCyc = cyc;
        checkOutput("stall_latency", doneCyc - startCyc, 7);
        checkResult("k1_1001", 8'd3, 16'd4, 1'b0);

        startDecode(4'd2);
        sendBins(32'b000, 3);
        checkResult("k2_000", 8'd0, 16'd3, 1'b0);

        startDecode(4'd3);
        sendBins(32'b0101, 4);
        checkResult("k3_0101", 8'd5, 16'd4, 1'b0);

        startDecode(4'd0);
        sendBins(32'h1FF, 9);
        checkResult("ovf_prefix", 8'd0, 16'd9, 1'b1);
        checkOutput("ovf_prefix_ready", bin_ready, 0);

        startDecode(4'd0);
        sendBins(32'b11111111_0_00000001, 17);
        checkResult("ovf_acc", 8'd0, 16'd17, 1'b1);

        // K=9 >= N: done in the cycle after start, no bins consumed.
        startDecode(4'd9);
        checkOutput("kbad_ready", bin_ready, 0);
        checkResult("kbad", 8'd0, 16'd0, 1'b1);

        // Reset mid-SUFFIX of '11010' discards the decode.
        startDecode(4'd0);
        sendBins(32'b1101, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", bin_ready, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_value", value, 0);
        checkOutput("midrst_len", bin_len, 0);
        checkOutput("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_nopulse", done, 0);
        end
        startDecode(4'd0);
        sendBins(32'b0, 1);
        checkResult("after_rst", 8'd0, 16'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
